serial_comparator_lsb: RTL and testbench

- Multi-cycle signed two's-complement magnitude comparator that processes operands 2 bits per clock, LSB digit first. This is the reverse scan order of the single-cycle MSB-first 16-bit comparator cascade.
- Used in area-constrained paths where a result within WIDTH/2 cycles is acceptable.
- Operands are captured on a start handshake; the gt/eq/lt flags are registered and held until the next completed compare.

---
 rtl/serial_comparator_lsb_if.sv | 16 +
 rtl/serial_comparator_lsb.sv | 117 +++++++++++
 tb/tb_serial_comparator_lsb.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/serial_comparator_lsb_if.sv
// Start/operand/result bundle for the LSB-first serial signed comparator.
interface serial_comparator_lsb_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;

  modport master (output start, A, B, input busy, done, gt, eq, lt);
  modport slave  (input start, A, B, output busy, done, gt, eq, lt);
endinterface

// File: rtl/serial_comparator_lsb.sv
// Signed two's-complement comparator scanning 2-bit digits LSB first;
// a differing higher digit overrides whatever the lower digits decided.
module serial_comparator_lsb #(
  parameter int unsigned WIDTH = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  serial_comparator_lsb_if.slave bus
);
  localparam int unsigned DIGITS = WIDTH / 2;
  localparam int unsigned CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Flag encodings ordered {gt, eq, lt}
  localparam logic [2:0] FLAG_NONE = 3'b000;
  localparam logic [2:0] FLAG_GT   = 3'b100;
  localparam logic [2:0] FLAG_EQ   = 3'b010;
  localparam logic [2:0] FLAG_LT   = 3'b001;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       run_q, run_d;
  logic [2:0]       res_q, res_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last_c;
  logic             dig_gt_c;
  logic             dig_lt_c;

  assign last_c = (cnt_q == CW'(DIGITS - 1));

  // Top digit carries the sign, so it alone is compared as signed
  always_comb begin
    dig_gt_c = 1'b0;
    dig_lt_c = 1'b0;
    if (last_c) begin
      dig_gt_c = $signed(a_q[1:0]) > $signed(b_q[1:0]);
      dig_lt_c = $signed(a_q[1:0]) < $signed(b_q[1:0]);
    end else begin
      dig_gt_c = a_q[1:0] > b_q[1:0];
      dig_lt_c = a_q[1:0] < b_q[1:0];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    run_d   = run_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          run_d   = FLAG_EQ;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (dig_gt_c)      run_d = FLAG_GT;
        else if (dig_lt_c) run_d = FLAG_LT;
        a_d   = a_q >> 2;
        b_d   = b_q >> 2;
        cnt_d = cnt_q + CW'(1);
        if (last_c) begin
          res_d   = run_d;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      run_q   <= FLAG_NONE;
      res_q   <= FLAG_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      run_q   <= run_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.gt   = res_q[2];
  assign bus.eq   = res_q[1];
  assign bus.lt   = res_q[0];
endmodule

// File: tb/tb_serial_comparator_lsb.sv
// Randomized and directed bench for serial_comparator_lsb against a signed-arithmetic model.
module tb_serial_comparator_lsb;
  localparam int unsigned W      = 16;
  localparam int unsigned DIGITS = W / 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [2:0] held;

  serial_comparator_lsb_if #(.WIDTH(W)) cif ();

  serial_comparator_lsb #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (cif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    if ($signed(a) > $signed(b))       return 3'b100;
    else if ($signed(a) < $signed(b))  return 3'b001;
    else                               return 3'b010;
  endfunction

  function automatic logic [2:0] flags();
    return {cif.gt, cif.eq, cif.lt};
  endfunction

  // Idle cycles: no done, not busy, flags hold
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); @(negedge clk);
      check("idle_done", 32'(cif.done), 32'd0);
      check("idle_busy", 32'(cif.busy), 32'd0);
      check("idle_flags", 32'(flags()), 32'(held));
    end
  endtask

  // Drive start at the current negedge; returns at the negedge of the done cycle.
  // noise: pulse start with A=B=0 mid-run and scramble operands after capture.
  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
    int lat;
    logic [2:0] exp;
    exp = model(a, b);
    cif.start = 1'b1;
    cif.A = a;
    cif.B = b;
    @(posedge clk); @(negedge clk);
    cif.start = 1'b0;
    if (noise) begin
      cif.A = W'($urandom);
      cif.B = W'($urandom);
    end
    check("busy_rise", 32'(cif.busy), 32'd1);
    lat = 0;
    while (lat < int'(DIGITS) + 4) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (noise && lat == 2) begin
        cif.start = 1'b1; cif.A = '0; cif.B = '0;
      end
      if (noise && lat == 3) begin
        cif.start = 1'b0; cif.A = W'($urandom); cif.B = W'($urandom);
      end
      if (cif.done) break;
      check("busy_run", 32'(cif.busy), 32'd1);
      check("flags_held_run", 32'(flags()), 32'(held));
    end
    check("done_seen", 32'(cif.done), 32'd1);
    check("latency", 32'(lat), 32'(DIGITS));
    check("busy_fall", 32'(cif.busy), 32'd0);
    check("result", 32'(flags()), 32'(exp));
    held = exp;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    n_checks = 0;
    n_fail   = 0;
    held     = 3'b000;
    rst_n     = 1'b0;
    cif.start = 1'b0;
    cif.A     = '0;
    cif.B     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(cif.busy), 32'd0);
    check("rst_done", 32'(cif.done), 32'd0);
    check("rst_flags", 32'(flags()), 32'd0);
    rst_n = 1'b1;
    idle(2);

    run_cmp(16'h0005, 16'h0003, 1'b0);
    idle(1);
    run_cmp(16'h8000, 16'h7FFF, 1'b0);
    idle(1);
    run_cmp(16'h7FFF, 16'h8000, 1'b0);
    idle(1);
    run_cmp(16'hFFFF, 16'hFFFF, 1'b0);
    idle(1);
    run_cmp(16'h8000, 16'h8000, 1'b0);
    idle(1);
    run_cmp(16'h0102, 16'h0201, 1'b0);
    idle(1);
    run_cmp(16'h1234, 16'h1235, 1'b0);
    idle(1);
    run_cmp(16'h4000, 16'h8000, 1'b0);
    idle(1);
    run_cmp(16'h0010, 16'h0001, 1'b1);
    // start in the done cycle: back-to-back
    run_cmp(16'hFFFE, 16'hFFFF, 1'b0);
    idle(2);

    // Reset mid-run
    cif.start = 1'b1; cif.A = 16'h0007; cif.B = 16'h0003;
    @(posedge clk); @(negedge clk);
    cif.start = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(cif.busy), 32'd0);
    check("arst_done", 32'(cif.done), 32'd0);
    check("arst_flags", 32'(flags()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    held = 3'b000;
    idle(DIGITS + 3);
    run_cmp(16'h0003, 16'h0007, 1'b0);
    idle(1);

    // Random compares with mixed gaps, noise and biased operands
    for (int i = 0; i < 60; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      run_cmp(ra, rb, 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end
endmodule
